// File: rtl/int_seq.sv
// Interrupt/reset entry sequencer for the 6502 core.
// Arbitrates RESET, NMI, IRQ and BRK at instruction boundaries, then walks the
// datapath through push PCH, push PCL, push P, vector low and vector high.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for rst_pend, or for inst_done with a request pending
// PCH   | push (or dummy-read for RESET) PC high byte, SP--
// PCL   | push (or dummy-read) PC low byte, SP--
// P     | push (or dummy-read) status byte, SP--, B bit driven for BRK
// VL    | fetch vector low byte into PCL (vector chosen on entry here)
// VH    | fetch vector high byte into PCH, set I, pulse seq_done
module int_seq #(
    parameter logic [15:0] VEC_NMI = 16'hFFFA,
    parameter logic [15:0] VEC_RST = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        irq_i,
    input  logic        nmi_i,
    input  logic        i_flag_i,
    input  logic        brk_i,
    input  logic        inst_done_i,
    output logic        busy_o,
    output logic [2:0]  seq_step_o,
    output logic [1:0]  push_sel_o,
    output logic        push_en_o,
    output logic        sp_dec_o,
    output logic [15:0] vec_addr_o,
    output logic        vec_lo_ld_o,
    output logic        vec_hi_ld_o,
    output logic        set_i_o,
    output logic        b_flag_o,
    output logic        seq_done_o
);

    // Encoding doubles as the seq_step output value.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PCH  = 3'd1,
        S_PCL  = 3'd2,
        S_P    = 3'd3,
        S_VL   = 3'd4,
        S_VH   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_NMI = 2'd1,
        SRC_IRQ = 2'd2,
        SRC_BRK = 2'd3
    } src_t;

    state_t      state_q, state_d;
    src_t        src_q, src_d;
    logic [15:0] vec_q, vec_d;
    logic        rst_pend_q, rst_pend_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic        nmi_q;
    logic        nmi_edge;

    logic        busy_q, busy_d;
    logic [2:0]  seq_step_q, seq_step_d;
    logic [1:0]  push_sel_q, push_sel_d;
    logic        push_en_q, push_en_d;
    logic        sp_dec_q, sp_dec_d;
    logic [15:0] vec_addr_q, vec_addr_d;
    logic        vec_lo_ld_q, vec_lo_ld_d;
    logic        vec_hi_ld_q, vec_hi_ld_d;
    logic        set_i_q, set_i_d;
    logic        b_flag_q, b_flag_d;
    logic        seq_done_q, seq_done_d;

    assign nmi_edge = nmi_i & ~nmi_q;

    // Next-state, pending-request and vector selection logic.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        vec_d      = vec_q;
        rst_pend_d = rst_pend_q;
        nmi_pend_d = nmi_pend_q | nmi_edge;
        case (state_q)
            S_IDLE: begin
                if (rst_pend_q) begin
                    state_d = S_PCH;
                    src_d   = SRC_RST;
                end else if (inst_done_i) begin
                    if (nmi_pend_q) begin
                        state_d = S_PCH;
                        src_d   = SRC_NMI;
                    end else if (irq_i && !i_flag_i) begin
                        state_d = S_PCH;
                        src_d   = SRC_IRQ;
                    end else if (brk_i) begin
                        state_d = S_PCH;
                        src_d   = SRC_BRK;
                    end
                end
            end
            S_PCH: state_d = S_PCL;
            S_PCL: state_d = S_P;
            S_P: begin
                // Vector is committed here so a late NMI edge can still hijack IRQ/BRK.
                state_d = S_VL;
                if (src_q == SRC_RST) begin
                    vec_d      = VEC_RST;
                    rst_pend_d = 1'b0;
                end else if (nmi_pend_q || nmi_edge) begin
                    vec_d      = VEC_NMI;
                    nmi_pend_d = 1'b0;
                end else begin
                    vec_d = VEC_IRQ;
                end
            end
            S_VL:    state_d = S_VH;
            S_VH:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the state being entered, so outputs come straight from flops.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        seq_step_d  = state_d;
        push_sel_d  = 2'd0;
        push_en_d   = 1'b0;
        sp_dec_d    = 1'b0;
        vec_addr_d  = 16'h0000;
        vec_lo_ld_d = 1'b0;
        vec_hi_ld_d = 1'b0;
        set_i_d     = 1'b0;
        b_flag_d    = 1'b0;
        seq_done_d  = 1'b0;
        case (state_d)
            S_PCH: begin
                push_sel_d = 2'd0;
                push_en_d  = (src_d != SRC_RST);
                sp_dec_d   = 1'b1;
            end
            S_PCL: begin
                push_sel_d = 2'd1;
                push_en_d  = (src_d != SRC_RST);
                sp_dec_d   = 1'b1;
            end
            S_P: begin
                push_sel_d = 2'd2;
                push_en_d  = (src_d != SRC_RST);
                sp_dec_d   = 1'b1;
                b_flag_d   = (src_d == SRC_BRK);
            end
            S_VL: begin
                vec_addr_d  = vec_d;
                vec_lo_ld_d = 1'b1;
            end
            S_VH: begin
                vec_addr_d  = vec_d + 16'd1;
                vec_hi_ld_d = 1'b1;
                set_i_d     = 1'b1;
                seq_done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // State, pending flags and registered outputs; reset aborts any sequence at once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            src_q       <= SRC_RST;
            vec_q       <= 16'h0000;
            rst_pend_q  <= 1'b1;
            nmi_pend_q  <= 1'b0;
            nmi_q       <= 1'b0;
            busy_q      <= 1'b0;
            seq_step_q  <= 3'd0;
            push_sel_q  <= 2'd0;
            push_en_q   <= 1'b0;
            sp_dec_q    <= 1'b0;
            vec_addr_q  <= 16'h0000;
            vec_lo_ld_q <= 1'b0;
            vec_hi_ld_q <= 1'b0;
            set_i_q     <= 1'b0;
            b_flag_q    <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            vec_q       <= vec_d;
            rst_pend_q  <= rst_pend_d;
            nmi_pend_q  <= nmi_pend_d;
            nmi_q       <= nmi_i;
            busy_q      <= busy_d;
            seq_step_q  <= seq_step_d;
            push_sel_q  <= push_sel_d;
            push_en_q   <= push_en_d;
            sp_dec_q    <= sp_dec_d;
            vec_addr_q  <= vec_addr_d;
            vec_lo_ld_q <= vec_lo_ld_d;
            vec_hi_ld_q <= vec_hi_ld_d;
            set_i_q     <= set_i_d;
            b_flag_q    <= b_flag_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign busy_o      = busy_q;
    assign seq_step_o  = seq_step_q;
    assign push_sel_o  = push_sel_q;
    assign push_en_o   = push_en_q;
    assign sp_dec_o    = sp_dec_q;
    assign vec_addr_o  = vec_addr_q;
    assign vec_lo_ld_o = vec_lo_ld_q;
    assign vec_hi_ld_o = vec_hi_ld_q;
    assign set_i_o     = set_i_q;
    assign b_flag_o    = b_flag_q;
    assign seq_done_o  = seq_done_q;

endmodule
